// File: rtl/vis_accumulator.sv
// Final-stage visibility accumulator: sums (count_i+1) blocks of N signed partial
// sums element-wise and streams the completed block out as one frame.
module vis_accumulator #(
    parameter int unsigned CORES = 3,
    parameter int unsigned TRATE = 15,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SBITS = 7
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WIDTH-SBITS:0] count_i,
    input  logic                 frame_i,
    input  logic                 valid_i,
    input  logic                 first_i,
    input  logic                 last_i,
    input  logic [SBITS-1:0]     revis_i,
    input  logic [SBITS-1:0]     imvis_i,
    output logic                 valid_o,
    output logic                 last_o,
    output logic [WIDTH-1:0]     revis_o,
    output logic [WIDTH-1:0]     imvis_o
);

    localparam int unsigned N  = CORES * TRATE;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = WIDTH - SBITS + 1;
    localparam int unsigned XW = WIDTH - SBITS;

    logic [WIDTH-1:0] re_mem [N];
    logic [WIDTH-1:0] im_mem [N];

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    blk_q, blk_d;
    logic [CW-1:0]    lim_q, lim_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] re_q, re_d;
    logic [WIDTH-1:0] im_q, im_d;

    logic             accept;
    logic             final_blk;
    logic             wr_en;
    logic [PW-1:0]    addr;
    logic [CW-1:0]    eff_lim;
    logic [WIDTH-1:0] re_base, im_base;
    logic [WIDTH-1:0] re_sum, im_sum;

    // Address, accumulate and bookkeeping; the first block of a frame uses count_i directly
    always_comb begin
        accept    = frame_i && valid_i;
        addr      = first_i ? PW'(0) : ptr_q;
        eff_lim   = (blk_q == CW'(0)) ? count_i : lim_q;
        final_blk = (blk_q == eff_lim);
        re_base   = (blk_q == CW'(0)) ? WIDTH'(0) : re_mem[addr];
        im_base   = (blk_q == CW'(0)) ? WIDTH'(0) : im_mem[addr];
        re_sum    = re_base + {{XW{revis_i[SBITS-1]}}, revis_i};
        im_sum    = im_base + {{XW{imvis_i[SBITS-1]}}, imvis_i};
        wr_en     = accept && !final_blk;

        ptr_d   = ptr_q;
        blk_d   = blk_q;
        lim_d   = lim_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        re_d    = re_q;
        im_d    = im_q;

        if (!frame_i) begin
            ptr_d = PW'(0);
            blk_d = CW'(0);
        end else if (accept) begin
            ptr_d = (last_i || addr == PW'(N - 1)) ? PW'(0) : addr + PW'(1);
            if (blk_q == CW'(0)) begin
                lim_d = count_i;
            end
            if (last_i) begin
                blk_d = final_blk ? CW'(0) : blk_q + CW'(1);
            end
            if (final_blk) begin
                valid_d = 1'b1;
                last_d  = last_i;
                re_d    = re_sum;
                im_d    = im_sum;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            blk_q   <= '0;
            lim_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            blk_q   <= blk_d;
            lim_q   <= lim_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    // Accumulator arrays are not reset; a frame's first block never reads them
    always_ff @(posedge clock) begin
        if (wr_en) begin
            re_mem[addr] <= re_sum;
            im_mem[addr] <= im_sum;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign revis_o = re_q;
    assign imvis_o = im_q;

endmodule

// File: tb/tb_vis_accumulator.sv
// Directed testbench for vis_accumulator: default 32-bit instance plus an 8-bit instance for wrap.
module tb_vis_accumulator;

    logic        clock;
    logic        reset_n;
    logic [25:0] count;
    logic [1:0]  count8;
    logic        frame, valid, first, last;
    logic [6:0]  re_in, im_in;
    logic        vo, lo, vo8, lo8;
    logic [31:0] reo, imo;
    logic [7:0]  reo8, imo8;

    int errors = 0;
    int checks = 0;

    assign count8 = count[1:0];

    vis_accumulator dut (
        .clock(clock), .reset_n(reset_n), .count_i(count), .frame_i(frame),
        .valid_i(valid), .first_i(first), .last_i(last), .revis_i(re_in), .imvis_i(im_in),
        .valid_o(vo), .last_o(lo), .revis_o(reo), .imvis_o(imo)
    );

    vis_accumulator #(.WIDTH(8), .SBITS(7)) dut8 (
        .clock(clock), .reset_n(reset_n), .count_i(count8), .frame_i(frame),
        .valid_i(valid), .first_i(first), .last_i(last), .revis_i(re_in), .imvis_i(im_in),
        .valid_o(vo8), .last_o(lo8), .revis_o(reo8), .imvis_o(imo8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs on the falling edge, then sample just after the rising edge
    task automatic step(input logic f, input logic v, input logic fi, input logic la,
                        input int re, input int im);
        @(negedge clock);
        frame = f; valid = v; first = fi; last = la;
        re_in = 7'(re); im_in = 7'(im);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if (vo !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", vo); end
        checks++; if (lo !== 1'b0) begin errors++; $display("FAIL reset_last got=%0b want=0", lo); end
        checks++; if (reo !== 32'h0) begin errors++; $display("FAIL reset_re got=%h want=0", reo); end
        checks++; if (imo !== 32'h0) begin errors++; $display("FAIL reset_im got=%h want=0", imo); end
        @(negedge clock);
        reset_n = 1'b1;
        count = 26'd0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 5, 5);
            checks++; if (vo !== 1'b0) begin errors++; $display("FAIL idle_valid i=%0d got=%0b want=0", i, vo); end
            checks++; if (reo !== 32'h0) begin errors++; $display("FAIL idle_re i=%0d got=%h want=0", i, reo); end
        end
    endtask

    task automatic test_direct();
        count = 26'd0;
        for (int k = 0; k < 45; k++) begin
            step(1'b1, 1'b1, k == 0, k == 44, 3, -2);
            checks++; if (vo !== 1'b1) begin errors++; $display("FAIL direct_valid k=%0d got=%0b want=1", k, vo); end
            checks++; if (lo !== (k == 44)) begin errors++; $display("FAIL direct_last k=%0d got=%0b want=%0b", k, lo, k == 44); end
            checks++; if (reo !== 32'd3) begin errors++; $display("FAIL direct_re k=%0d got=%h want=3", k, reo); end
            checks++; if (imo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL direct_im k=%0d got=%h want=fffffffe", k, imo); end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        checks++; if (vo !== 1'b0) begin errors++; $display("FAIL direct_drop got=%0b want=0", vo); end
        checks++; if (reo !== 32'd3) begin errors++; $display("FAIL direct_hold got=%h want=3", reo); end
    endtask

    task automatic test_accumulate();
        logic [31:0] exp_re, exp_im;
        count = 26'd3;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 45; k++) begin
                step(1'b1, 1'b1, k == 0, k == 44, k, -k);
                exp_re = 32'(4 * k);
                exp_im = 32'(-(4 * k));
                if (b < 3) begin
                    checks++; if (vo !== 1'b0) begin errors++; $display("FAIL accum_quiet b=%0d k=%0d got=%0b want=0", b, k, vo); end
                end else begin
                    checks++; if (vo !== 1'b1) begin errors++; $display("FAIL accum_valid k=%0d got=%0b want=1", k, vo); end
                    checks++; if (lo !== (k == 44)) begin errors++; $display("FAIL accum_last k=%0d got=%0b want=%0b", k, lo, k == 44); end
                    checks++; if (reo !== exp_re) begin errors++; $display("FAIL accum_re k=%0d got=%h want=%h", k, reo, exp_re); end
                    checks++; if (imo !== exp_im) begin errors++; $display("FAIL accum_im k=%0d got=%h want=%h", k, imo, exp_im); end
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Two count_i=1 frames back to back with frame_i held high
    task automatic test_back_to_back();
        int          val;
        logic [31:0] exp_re;
        count = 26'd1;
        for (int b = 0; b < 4; b++) begin
            val    = (b < 2) ? -64 : 63;
            exp_re = (b == 1) ? 32'hFFFF_FF80 : 32'd126;
            for (int k = 0; k < 45; k++) begin
                step(1'b1, 1'b1, k == 0, k == 44, val, 0);
                checks++; if (vo !== (b == 1 || b == 3)) begin errors++; $display("FAIL b2b_valid b=%0d k=%0d got=%0b", b, k, vo); end
                if (b == 1 || b == 3) begin
                    checks++; if (reo !== exp_re) begin errors++; $display("FAIL b2b_re b=%0d k=%0d got=%h want=%h", b, k, reo, exp_re); end
                    checks++; if (imo !== 32'h0) begin errors++; $display("FAIL b2b_im b=%0d k=%0d got=%h want=0", b, k, imo); end
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_wrap();
        count = 26'd2;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 45; k++) begin
                step(1'b1, 1'b1, k == 0, k == 44, 63, 0);
                checks++; if (vo8 !== (b == 2)) begin errors++; $display("FAIL wrap_valid b=%0d k=%0d got=%0b", b, k, vo8); end
                if (b == 2) begin
                    checks++; if (reo8 !== 8'hBD) begin errors++; $display("FAIL wrap_re8 k=%0d got=%h want=bd", k, reo8); end
                    checks++; if (reo !== 32'd189) begin errors++; $display("FAIL wrap_re32 k=%0d got=%h want=bd", k, reo); end
                    checks++; if (lo8 !== (k == 44)) begin errors++; $display("FAIL wrap_last k=%0d got=%0b want=%0b", k, lo8, k == 44); end
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_midreset();
        count = 26'd3;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 45; k++) begin
                step(1'b1, 1'b1, k == 0, k == 44, 5, 7);
            end
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, k == 0, 1'b0, 5, 7);
        end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if (vo !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b want=0", vo); end
        checks++; if (reo !== 32'h0) begin errors++; $display("FAIL midrst_re got=%h want=0", reo); end
        checks++; if (imo !== 32'h0) begin errors++; $display("FAIL midrst_im got=%h want=0", imo); end
        @(negedge clock);
        reset_n = 1'b1;
        count = 26'd1;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 45; k++) begin
                step(1'b1, 1'b1, k == 0, k == 44, 1, 1);
                checks++; if (vo !== (b == 1)) begin errors++; $display("FAIL fresh_valid b=%0d k=%0d got=%0b", b, k, vo); end
                if (b == 1) begin
                    checks++; if (reo !== 32'd2) begin errors++; $display("FAIL fresh_re k=%0d got=%h want=2", k, reo); end
                    checks++; if (imo !== 32'd2) begin errors++; $display("FAIL fresh_im k=%0d got=%h want=2", k, imo); end
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        checks++; if (vo !== 1'b0) begin errors++; $display("FAIL fresh_drop got=%0b want=0", vo); end
    endtask

    initial begin
        reset_n = 1'b1;
        count = '0;
        frame = 1'b0; valid = 1'b0; first = 1'b0; last = 1'b0;
        re_in = '0; im_in = '0;
        #2;
        test_reset();
        test_direct();
        test_accumulate();
        test_back_to_back();
        test_wrap();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
